// File: rtl/pipe_stage_hs.sv
// Elastic valid/ready pipeline stage with flush and bubble-gated control; define PIPE_STAGE_SKID_EN for a
// registered in_ready via a second (skid) entry. Latency 1 cycle; stalls hold entries, never drop them.
module pipe_stage_hs #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occ
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  ent_t in_ent;
  ent_t m_q;
  logic m_vld;
  logic in_fire;

  assign in_ent = '{ctrl: in_ctrl, data: in_data, tag: in_tag};

`ifdef PIPE_STAGE_SKID_EN
  ent_t s_q;
  logic s_vld;

  // Ready depends only on the skid slot, so out_ready never reaches in_ready.
  assign in_ready = ~s_vld & ~flush;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (~m_vld | out_ready) begin
      if (s_vld) begin
        m_q   <= s_q;
        m_vld <= 1'b1;
        s_vld <= 1'b0;
      end else if (in_fire) begin
        m_q   <= in_ent;
        m_vld <= 1'b1;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (in_fire) begin
      s_q   <= in_ent;
      s_vld <= 1'b1;
    end
  end

  assign occ = {1'b0, m_vld} + {1'b0, s_vld};
`else
  assign in_ready = (~m_vld | out_ready) & ~flush;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld <= 1'b0;
      m_q   <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
    end else if (in_fire) begin
      m_q   <= in_ent;
      m_vld <= 1'b1;
    end else if (out_ready) begin
      m_vld <= 1'b0;
    end
  end

  assign occ = {1'b0, m_vld};
`endif

  // Data and tag keep stale values on bubbles; only ctrl is gated so enables stay low.
  assign out_valid = m_vld;
  assign out_ctrl  = m_q.ctrl & {CTRL_W{m_vld}};
  assign out_data  = m_q.data;
  assign out_tag   = m_q.tag;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: scoreboard of accepted entries checked at every output transfer.
module tb_pipe_stage_hs;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_ctrl;
  logic [63:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  occ;

  typedef struct packed {
    logic [2:0]  c;
    logic [63:0] d;
    logic [4:0]  t;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  pipe_stage_hs #(.CTRL_W(3), .DATA_W(64), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_tag(out_tag),
    .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] t, input logic [2:0] c);
    in_valid = v;
    in_data  = d;
    in_tag   = t;
    in_ctrl  = c;
  endtask

  // Monitor: transfers are sampled on the falling edge, half a cycle before the edge that commits them.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got data %0h expected no transfer", out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_tag", 64'(out_tag), 64'(e.t));
          chk("sb_ctrl", 64'(out_ctrl), 64'(e.c));
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back('{c: in_ctrl, d: in_data, t: in_tag});
    end
  end

  initial begin
    // Reset with garbage on the input.
    drive(1'b1, 64'hdead, 5'd9, 3'b111);
    step();
    step();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 3'd0);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming 1..8 with out_ready high.
    step();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 64'(k), 5'(k), 3'(k));
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (k > 1) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_data", out_data, 64'(k - 1));
      end
      step();
    end
    drive(1'b0, 64'd0, 5'd0, 3'd0);
    @(negedge clk);
    chk("stream_last", out_data, 64'd8);
    step();
    @(negedge clk);
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: A then B with downstream stalled.
    step();
    out_ready = 1'b0;
    drive(1'b1, 64'h11, 5'd2, 3'b101);
    step();
    drive(1'b1, 64'h22, 5'd3, 3'b101);
    @(negedge clk);
    chk("bp_b_ready", 64'(in_ready), SKID ? 64'd1 : 64'd0);
    step();
    drive(1'b0, 64'd0, 5'd0, 3'd0);
    @(negedge clk);
    chk("bp_occ", 64'(occ), SKID ? 64'd2 : 64'd1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_hold", out_data, 64'h11);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first", out_data, 64'h11);
    step();
    @(negedge clk);
    chk("bp_second_valid", 64'(out_valid), SKID ? 64'd1 : 64'd0);
    chk("bp_occ_after", 64'(occ), SKID ? 64'd1 : 64'd0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    if (SKID) chk("bp_second", out_data, 64'h22);
    step();
    @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush a full stage while an input is offered.
    step();
    out_ready = 1'b0;
    drive(1'b1, 64'h44, 5'd4, 3'b101);
    step();
    drive(1'b1, 64'h55, 5'd5, 3'b101);
    step();
    drive(1'b1, 64'h66, 5'd6, 3'b101);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_pre_occ", 64'(occ), SKID ? 64'd2 : 64'd1);
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 3'd0);
    @(negedge clk);
    chk("fl_occ", 64'(occ), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_data_kept", out_data, 64'h44);
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("fl_no_ghost", 64'(out_valid), 64'd0);

    // Bubble gating after a single ctrl=111 entry.
    step();
    out_ready = 1'b0;
    drive(1'b1, 64'h77, 5'd7, 3'b111);
    step();
    drive(1'b0, 64'd0, 5'd0, 3'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bub_ctrl_live", 64'(out_ctrl), 64'd7);
    step();
    @(negedge clk);
    chk("bub_valid", 64'(out_valid), 64'd0);
    chk("bub_ctrl", 64'(out_ctrl), 64'd0);
    chk("bub_data", out_data, 64'h77);

    // Simultaneous in/out with one entry held.
    step();
    out_ready = 1'b0;
    drive(1'b1, 64'h80, 5'd16, 3'b010);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h81 + 64'(i), 5'(17 + i), 3'b010);
      out_ready = 1'b1;
      @(negedge clk);
      chk("sim_occ", 64'(occ), 64'd1);
      chk("sim_ready", 64'(in_ready), 64'd1);
      chk("sim_data", out_data, 64'h80 + 64'(i));
      step();
    end
    drive(1'b0, 64'd0, 5'd0, 3'd0);
    @(negedge clk);
    chk("sim_last", out_data, 64'h84);
    chk("sim_last_occ", 64'(occ), 64'd1);
    step();
    @(negedge clk);
    chk("sim_done_occ", 64'(occ), 64'd0);

    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised elastic pipeline stage register with valid/ready handshake, synchronous flush, and bubble-safe control gating. It is the next generation of the fixed-width stage registers used between ID/EX, EX/MEM and MEM/WB. It lets any boundary stall backpressure-free or be killed by a branch or exception without corrupting write enables. An optional skid buffer registers the upstream ready path for timing closure.

## Interface
Parameters:
- CTRL_W, 3: width of control bundle (e.g. wreg, m2reg, wmem); zeroed on bubbles.
- DATA_W, 64: width of data payload (e.g. alu result concatenated with store operand).
- TAG_W, 5: width of destination register tag.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  stage accepts an entry this cycle.
- in_ctrl  input  CTRL_W  control bundle.
- in_data  input  DATA_W  data payload.
- in_tag  input  TAG_W  destination tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head this cycle.
- out_ctrl  output  CTRL_W  head control; forced 0 when out_valid=0.
- out_data  output  DATA_W  head payload.
- out_tag  output  TAG_W  head tag.
- occ  output  2  entries held (0..2; max 1 without skid).

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush or rst.
- Main register (M) drives outputs.
  - M loads when empty or when its head is consumed.
  - Its source is the skid entry (S) if one is held, else the input.
- Skid mode: an input accepted while M is held and not consumed goes to S.
  - S is never written when S is already valid.
- out_ctrl = M.ctrl & {CTRL_W{M.valid}}. Bubbles can never assert write or memory enables.
- flush: M.valid and S.valid are cleared to 0 on the next edge.
  - Data and tag registers keep their old values.
  - in_ready = 0 while flush = 1, so no input is accepted in a flush cycle.
- rst: clears all valid bits and all ctrl, data and tag registers to 0. rst has priority over flush.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, out_tag=0, occ=0. in_ready=1 on the cycle after rst deasserts.
- Simultaneous in and out transfers with M valid and S empty: M takes the input, occ unchanged.
- Full in skid mode (occ=2): in_ready=0. A consume moves S into M (occ becomes 1) and in_ready rises the following cycle.

## Timing
- Latency: an entry accepted at edge N appears on out_* after edge N.
- Throughput: 1 entry per cycle when out_ready is held high.
- Skid mode: in_ready = ~S.valid & ~flush. Apart from flush, it depends only on registered state, with no combinational path from out_ready.
- Non-skid mode: in_ready = (~M.valid | out_ready) & ~flush, which is combinational from out_ready.
- out_* are driven directly from registers, with no combinational path from in_*.
- occ reflects registered state only.

## Configuration
- PIPE_STAGE_SKID_EN defined: second entry S is present and in_ready is registered as above. occ ranges 0..2.
- PIPE_STAGE_SKID_EN undefined: no S register, and in_ready is combinational as above. occ ranges 0..1 and bit 1 is tied to 0.
- Port list is identical in both builds.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1, in_ctrl=3'b111. Then expect out_valid=0, out_ctrl=0, out_data=0, occ=0, and in_ready=1 the cycle after release.
- Streaming: present 8 entries with data 1..8 and tags 1..8 with out_ready=1. Expect outputs 1..8 on consecutive cycles starting 1 cycle after the first accept, with no gaps.
- Backpressure (skid build): send A=0x11 then B=0x22 with out_ready=0. Expect occ=2, in_ready=0 and out_data=0x11 held. Raise out_ready and expect 0x11 then 0x22 in order.
- Flush: with occ=2 and ctrl=3'b101, assert flush with in_valid=1. Expect occ=0 and out_valid=0 next cycle, out_ctrl=0, and the flush-cycle input not accepted.
- Bubble gating: send a single entry with ctrl=3'b111 and leave in_valid=0 afterwards. After it is consumed, expect out_ctrl=0 even though out_data retains its last value.
- Simultaneous transfer: with occ=1, drive in_valid=1 and out_ready=1 for 4 cycles. Expect occ to stay at 1 with new data appearing every cycle.
